fixed_point_adder_arbiter: RTL

Round-robin arbiter that shares one signed pipelined Q4.4 fixed-point adder among NUM_REQ requesters. It accepts at most one operand pair per cycle, drives registered operands into the adder, and tracks the requester ID through a tag pipeline matched to the adder latency. Each result returns to its originator as a one-hot response with a shared sum bus. It sits between client blocks and the signed_pipelined_fixed_point_adder instance.

---
 rtl/fxadd_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/fixed_point_adder_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fxadd_arb_pkg.sv
// Shared types for the fixed-point adder arbiter: requester tag and Q4.4 clamp helper.
// The tag ID is sized for the largest supported NUM_REQ so one tag type serves every build.
package fxadd_arb_pkg;

  localparam int unsigned NUM_REQ_MAX = 8;
  localparam int unsigned ID_W        = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } fxadd_tag_t;

  // Clamp a 9-bit signed sum to the 8-bit signed range, kept sign-extended to 9 bits.
  function automatic logic [8:0] sat9to8(input logic [8:0] s);
    logic [8:0] r;
    r = s;
    if (s[8] != s[7]) begin
      r = {s[8], s[8], {7{~s[8]}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr_i and wraps; first request wins.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] idx_o,
  output logic           vld_o
);

  logic [31:0]  cand;
  logic [N-1:0] rot;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    rot   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      rot = req_i >> cand;
      if (!vld_o && rot[0]) begin
        vld_o = 1'b1;
        gnt_o = N'(1) << cand;
        idx_o = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/fixed_point_adder_arbiter.sv
// Shares one pipelined signed fixed-point adder among NUM_REQ requesters, round-robin.
// Define FXADD_ARB_SAT_EN to clamp results to the DATA_W signed range and add rsp_sat.
module fixed_point_adder_arbiter
  import fxadd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]           add_a,
  output logic [DATA_W-1:0]           add_b,
  input  logic [DATA_W:0]             add_sum,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W:0]             rsp_sum,
  output logic                        busy
`ifdef FXADD_ARB_SAT_EN
  ,
  output logic                        rsp_sat
`endif
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_vld;
  logic               xfer;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  add_a_q, add_a_d;
  logic [DATA_W-1:0]  add_b_q, add_b_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]    rsp_sum_q, rsp_sum_d;
  logic [DATA_W:0]    sum_res;
  logic               tag_any;

  fxadd_tag_t tag_q [PIPE_LAT+1];
  fxadd_tag_t tag_d [PIPE_LAT+1];
  fxadd_tag_t tag_out;

`ifdef FXADD_ARB_SAT_EN
  logic rsp_sat_q, rsp_sat_d;
  logic sum_ovf;
`endif

  rr_arbiter #(
    .N   (NUM_REQ),
    .IdW (ID_W)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  // Grant, operand capture and tag shift.
  always_comb begin
    xfer      = gnt_vld & ~rst;
    req_ready = xfer ? gnt : '0;
    rr_ptr_d  = rr_ptr_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    if (xfer) begin
      rr_ptr_d = gnt_idx;
      add_a_d  = DATA_W'(req_a >> (DATA_W * 32'(gnt_idx)));
      add_b_d  = DATA_W'(req_b >> (DATA_W * 32'(gnt_idx)));
    end
    tag_d[0] = '{vld: xfer, id: gnt_idx};
    for (int unsigned k = 1; k <= PIPE_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int unsigned k = 0; k <= PIPE_LAT; k++) begin
      tag_any = tag_any | tag_q[k].vld;
    end
    tag_out = tag_q[PIPE_LAT];
  end

  // The tag leaving the last stage lines up with add_sum for the same operation.
  always_comb begin
`ifdef FXADD_ARB_SAT_EN
    sum_ovf   = add_sum[DATA_W] ^ add_sum[DATA_W-1];
    sum_res   = sum_ovf ? {add_sum[DATA_W], add_sum[DATA_W], {(DATA_W-1){~add_sum[DATA_W]}}}
                        : add_sum;
    rsp_sat_d = tag_out.vld & sum_ovf;
`else
    sum_res   = add_sum;
`endif
    rsp_valid_d = tag_out.vld ? (NUM_REQ'(1) << tag_out.id) : '0;
    rsp_sum_d   = tag_out.vld ? sum_res : rsp_sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
`ifdef FXADD_ARB_SAT_EN
      rsp_sat_q   <= 1'b0;
`endif
      for (int unsigned k = 0; k <= PIPE_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
`ifdef FXADD_ARB_SAT_EN
      rsp_sat_q   <= rsp_sat_d;
`endif
      for (int unsigned k = 0; k <= PIPE_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (|req_valid) | tag_any;
`ifdef FXADD_ARB_SAT_EN
  assign rsp_sat   = rsp_sat_q;
`endif

endmodule
